// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick divider.
// Shadowed period/mode per channel, applied only at period boundaries.
module clk_div_multi #(
  parameter int CH = 4,
  parameter int W = 17,
  parameter int DEF_DIV = 100000,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [CH-1:0] en_i,
  input  logic          restart_i,
  input  logic          wr_en_i,
  input  logic [CW-1:0] wr_ch_i,
  input  logic [W-1:0]  wr_div_i,
  input  logic          wr_mode_i,
  output logic [CH-1:0] out_o,
  output logic [CH-1:0] tick_o,
  output logic [CH-1:0] pend_o
);

  localparam logic [W-1:0] DEF = W'(DEF_DIV);

  logic [W-1:0]  cnt [CH];
  logic [W-1:0]  per [CH];
  logic [W-1:0]  sp  [CH];
  logic [CH-1:0] mode;
  logic [CH-1:0] sm;
  logic [CH-1:0] pend;
  logic [CH-1:0] out_q;
  logic [CH-1:0] tick_q;
  logic [CH-1:0] wrap;
  logic [CH-1:0] clr;
  logic [CH-1:0] apply;
  logic [CH-1:0] wr_hit;

  // Per-channel wrap, clear, shadow-apply and write-select decode
  always_comb begin
    wrap = '0;
    clr = '0;
    apply = '0;
    wr_hit = '0;
    for (int c = 0; c < CH; c++) begin
      // P of 0 or 1 wraps every cycle; cnt is held at 0 then
      if (per[c] <= W'(1))
        wrap[c] = 1'b1;
      else
        wrap[c] = (cnt[c] == per[c] - W'(1));
      clr[c] = restart_i | ~en_i[c];
      apply[c] = pend[c] & (clr[c] | wrap[c]);
      wr_hit[c] = wr_en_i &
        ({1'b0, wr_ch_i} == (CW+1)'(c));
    end
  end

  // Channel counters, outputs and active/shadow config
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CH; c++) begin
        cnt[c] <= '0;
        per[c] <= DEF;
        sp[c]  <= DEF;
      end
      mode   <= '0;
      sm     <= '0;
      pend   <= '0;
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (clr[c]) begin
          cnt[c]    <= '0;
          out_q[c]  <= 1'b0;
          tick_q[c] <= 1'b0;
        end else if (wrap[c]) begin
          cnt[c]    <= '0;
          tick_q[c] <= 1'b1;
          if (pend[c] && sm[c] && !mode[c])
            out_q[c] <= 1'b0;
          else if (mode[c])
            out_q[c] <= 1'b1;
          else
            out_q[c] <= ~out_q[c];
        end else begin
          cnt[c]    <= cnt[c] + W'(1);
          tick_q[c] <= 1'b0;
          if (mode[c])
            out_q[c] <= 1'b0;
        end

        if (apply[c]) begin
          per[c]  <= sp[c];
          mode[c] <= sm[c];
        end

        if (wr_hit[c]) begin
          sp[c]   <= wr_div_i;
          sm[c]   <= wr_mode_i;
          pend[c] <= 1'b1;
        end else if (apply[c]) begin
          pend[c] <= 1'b0;
        end
      end
    end
  end

  assign out_o  = out_q;
  assign tick_o = tick_q;
  assign pend_o = pend;

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized and directed bench for clk_div_multi.
// Reference model tracks edges remaining until each channel's next wrap.
module tb_clk_div_multi;

  localparam int CH = 4;
  localparam int W = 17;
  localparam int DD = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] en = '1;
  logic          restart = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_ch = '0;
  logic [W-1:0]  wr_div = '0;
  logic          wr_mode = 1'b0;
  logic [CH-1:0] out_o;
  logic [CH-1:0] tick_o;
  logic [CH-1:0] pend_o;

  int cmp = 0;
  int errs = 0;

  int rem [CH];
  int per [CH];
  int sp  [CH];
  bit md  [CH];
  bit sm  [CH];
  bit pd  [CH];
  bit ov  [CH];
  bit tv  [CH];

  always #5 clk = ~clk;

  clk_div_multi #(.CH(CH), .W(W), .DEF_DIV(DD)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .en_i(en),
    .restart_i(restart),
    .wr_en_i(wr_en),
    .wr_ch_i(wr_ch),
    .wr_div_i(wr_div),
    .wr_mode_i(wr_mode),
    .out_o(out_o),
    .tick_o(tick_o),
    .pend_o(pend_o)
  );

  function automatic int pe(int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic logic [11:0] expv();
    logic [11:0] v;
    for (int c = 0; c < CH; c++) begin
      v[8+c] = ov[c];
      v[4+c] = tv[c];
      v[c]   = pd[c];
    end
    return v;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < CH; c++) begin
      per[c] = DD; sp[c] = DD;
      md[c] = 0; sm[c] = 0; pd[c] = 0;
      ov[c] = 0; tv[c] = 0;
      rem[c] = DD;
    end
  endtask

  task automatic m_apply(int c);
    if (pd[c]) begin
      per[c] = sp[c]; md[c] = sm[c]; pd[c] = 0;
    end
  endtask

  // one clock edge on DUT and model; inputs stable across the edge
  task automatic step();
    @(posedge clk);
    for (int c = 0; c < CH; c++) begin
      if (restart || !en[c]) begin
        ov[c] = 0; tv[c] = 0;
        m_apply(c);
        rem[c] = pe(per[c]);
      end else begin
        rem[c]--;
        if (rem[c] == 0) begin
          tv[c] = 1;
          if (pd[c] && sm[c] && !md[c]) ov[c] = 0;
          else if (md[c]) ov[c] = 1;
          else ov[c] = ~ov[c];
          m_apply(c);
          rem[c] = pe(per[c]);
        end else begin
          tv[c] = 0;
          if (md[c]) ov[c] = 0;
        end
      end
      if (wr_en && int'(wr_ch) == c) begin
        sp[c] = int'(wr_div); sm[c] = wr_mode; pd[c] = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = '1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp++;
    if ({out_o, tick_o, pend_o} !== 12'h0) begin
      errs++;
      $display("FAIL reset_state got=%h exp=000",
        {out_o, tick_o, pend_o});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_default_div(string nm);
    int n = 0;
    bit seen = 0;
    for (int i = 1; i <= 3*DD && !seen; i++) begin
      step();
      cmp++;
      if ({out_o, tick_o, pend_o} !== expv()) begin
        errs++;
        $display("FAIL %s_model cyc=%0d got=%h exp=%h",
          nm, i, {out_o, tick_o, pend_o}, expv());
      end
      if (out_o[0]) begin seen = 1; n = i; end
    end
    cmp++;
    if (n !== DD) begin
      errs++;
      $display("FAIL %s_first_toggle got=%0d exp=%0d", nm, n, DD);
    end
    for (int i = 0; i < 2*DD + 3; i++) begin
      step();
      cmp++;
      if ({out_o, tick_o, pend_o} !== expv()) begin
        errs++;
        $display("FAIL %s_run got=%h exp=%h",
          nm, {out_o, tick_o, pend_o}, expv());
      end
    end
  endtask

  task automatic wr(int ch, int p, bit m);
    wr_en = 1; wr_ch = 2'(ch); wr_div = W'(p); wr_mode = m;
  endtask

  task automatic test_shadow_write();
    int t [$];
    int wd = 0;
    wr(0, 10, 0); step(); wr_en = 0;
    restart = 1; step(); restart = 0;
    while (!tick_o[0] && wd < 40) begin step(); wd++; end
    cmp++;
    if (wd >= 40) begin
      errs++;
      $display("FAIL shadow_wait got=timeout exp=tick");
    end
    step(); step();
    wr(0, 4, 0); step(); wr_en = 0;
    cmp++;
    if (pend_o[0] !== 1'b1) begin
      errs++;
      $display("FAIL shadow_pend got=%b exp=1", pend_o[0]);
    end
    for (int i = 0; i < 24; i++) begin
      step();
      cmp++;
      if ({out_o, tick_o, pend_o} !== expv()) begin
        errs++;
        $display("FAIL shadow_model got=%h exp=%h",
          {out_o, tick_o, pend_o}, expv());
      end
      if (tick_o[0]) t.push_back(i);
    end
    cmp++;
    if (t.size() < 3 || t[t.size()-1] - t[t.size()-2] != 4
        || t[1] - t[0] != 4) begin
      errs++;
      $display("FAIL shadow_spacing got=%0d ticks exp=4-cycle spacing",
        t.size());
    end
  endtask

  task automatic test_write_on_wrap();
    int wd = 0;
    while (rem[2] != 1 && wd < 40) begin step(); wd++; end
    wr(2, 5, 1); step(); wr_en = 0;
    cmp++;
    if (tick_o[2] !== 1'b1 || pend_o[2] !== 1'b1) begin
      errs++;
      $display("FAIL wrap_write got=t%b p%b exp=t1 p1",
        tick_o[2], pend_o[2]);
    end
    for (int i = 0; i < 3*DD + 12; i++) begin
      step();
      cmp++;
      if ({out_o, tick_o, pend_o} !== expv()) begin
        errs++;
        $display("FAIL wrap_model got=%h exp=%h",
          {out_o, tick_o, pend_o}, expv());
      end
    end
    cmp++;
    if (md[2] !== 1'b1 || per[2] != 5 || pend_o[2] !== 1'b0) begin
      errs++;
      $display("FAIL wrap_applied got=pend%b exp=pend0", pend_o[2]);
    end
  endtask

  task automatic test_p0_p1();
    logic prev;
    for (int p = 0; p < 2; p++) begin
      wr(1, p, 0); step(); wr_en = 0;
      restart = 1; step(); restart = 0;
      step();
      prev = out_o[1];
      for (int i = 0; i < 6; i++) begin
        step();
        cmp++;
        if (tick_o[1] !== 1'b1 || out_o[1] !== ~prev) begin
          errs++;
          $display("FAIL p%0d_fast got=t%b o%b exp=t1 o%b",
            p, tick_o[1], out_o[1], ~prev);
        end
        prev = out_o[1];
      end
    end
  endtask

  task automatic test_restart();
    wr(3, 7, 0); step(); wr_en = 0;
    step();
    restart = 1; step(); restart = 0;
    cmp++;
    if ({out_o, tick_o, pend_o} !== 12'h0) begin
      errs++;
      $display("FAIL restart_clear got=%h exp=000",
        {out_o, tick_o, pend_o});
    end
    for (int i = 1; i <= 7; i++) begin
      step();
      cmp++;
      if (tick_o[3] !== (i == 7)) begin
        errs++;
        $display("FAIL restart_tick3 cyc=%0d got=%b exp=%b",
          i, tick_o[3], (i == 7));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      restart = ($urandom_range(0, 50) == 0);
      if ($urandom_range(0, 5) == 0)
        wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
          1'($urandom));
      else
        wr_en = 0;
      step();
      cmp++;
      if ({out_o, tick_o, pend_o} !== expv()) begin
        errs++;
        $display("FAIL random cyc=%0d got=%h exp=%h",
          i, {out_o, tick_o, pend_o}, expv());
      end
    end
    en = '1; restart = 0; wr_en = 0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) begin
      en = 4'($urandom) | 4'h1;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if ({out_o, tick_o, pend_o} !== 12'h0) begin
      errs++;
      $display("FAIL async_reset got=%h exp=000",
        {out_o, tick_o, pend_o});
    end
    en = '1;
    m_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    test_default_div("post_reset");
  endtask

  initial begin
    test_reset();
    test_default_div("default");
    test_shadow_write();
    test_write_on_wrap();
    test_p0_p1();
    test_restart();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
